// File: rtl/sync_fifo_ext_if.sv
// sync_fifo_ext_if: handshake bundle between a producer/consumer pair and
// sync_fifo_ext.
//   master : drives flush, wr_en, data_in, rd_en; observes all status/data
//   slave  : the FIFO side; drives data_out, full/empty, almost flags,
//            count, overflow, underflow
// Parameters must match those given to the sync_fifo_ext instance.
interface sync_fifo_ext_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  full;
   logic                  almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  empty;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, wr_en, data_in, rd_en,
      input  full, almost_full, data_out, empty, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, data_in, rd_en,
      output full, almost_full, data_out, empty, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: single-clock FIFO with arbitrary depth (>= 2), selectable
// standard (registered, 1-cycle) or first-word-fall-through read, occupancy
// count, programmable almost-full/almost-empty, synchronous flush and sticky
// overflow/underflow flags.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sync_fifo_ext_if.slave -- flush, wr_en/data_in, rd_en/data_out,
//          full, almost_full, empty, almost_empty, count, overflow, underflow
module sync_fifo_ext #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int FWFT       = 0,
   parameter int AF_THRESH  = FIFO_DEPTH - 1,
   parameter int AE_THRESH  = 1
) (
   input logic            clk,
   input logic            rst,
   sync_fifo_ext_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  full_w;
   logic                  empty_w;
   logic                  wr_acc;
   logic                  rd_acc;

   // Pointers wrap explicitly so any depth works without a spare MSB.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);

   // Flush wins over both requests, so it also masks acceptance here.
   assign wr_acc = bus.wr_en & ~full_w  & ~bus.flush;
   assign rd_acc = bus.rd_en & ~empty_w & ~bus.flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (bus.wr_en & full_w)  overflow_q  <= 1'b1;
         if (bus.rd_en & empty_w) underflow_q <= 1'b1;
      end
   end

   // Storage is not reset or flushed; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= bus.data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Forced to zero while empty so stale or unwritten entries never show.
         assign bus.data_out = empty_w ? '0 : mem[rd_ptr];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)         dout_q <= '0;
            else if (rd_acc) dout_q <= mem[rd_ptr];
         end
         assign bus.data_out = dout_q;
      end
   endgenerate

   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised single-clock FIFO, the successor to the basic dual-port synchronous FIFO. Adds non-power-of-two depth, a selectable first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between any producer/consumer pair in one clock domain, such as UART and bus-bridge buffering or stream decoupling.

## Interface
- DATA_WIDTH, 8: width of each entry.
- FIFO_DEPTH, 8: number of entries; any integer ≥ 2, not restricted to powers of two.
- FWFT, 0: read mode. 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.
- AF_THRESH, FIFO_DEPTH-1: almost_full asserts when count ≥ AF_THRESH. Legal range 1..FIFO_DEPTH.
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH. Legal range 0..FIFO_DEPTH-1.
- CW (localparam): $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- full  out  1  no free entries.
- almost_full  out  1  count ≥ AF_THRESH.
- rd_en  in  1  read request (pop).
- data_out  out  DATA_WIDTH  read data.
- empty  out  1  no entries.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  CW  current occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- State consists of wr_ptr and rd_ptr (each 0..FIFO_DEPTH-1), count (CW bits), the storage array, the data_out register (standard mode only), and the two error flags.
- Pointer increment wraps explicitly: FIFO_DEPTH-1 → 0. Pointers carry no extra MSB. full and empty are derived from count only: full = (count == FIFO_DEPTH), empty = (count == 0).
- Write acceptance: wr_acc = wr_en & ~full. On acceptance, mem[wr_ptr] ← data_in and wr_ptr advances.
- Read acceptance: rd_acc = rd_en & ~empty. On acceptance, rd_ptr advances.
- Acceptance is judged on the flags at the start of the cycle:
  - Full with wr_en & rd_en: the read is accepted, the write is rejected, and overflow is set.
  - Empty with wr_en & rd_en: the write is accepted, the read is rejected, and underflow is set.
- count updates: +1 when only wr_acc, −1 when only rd_acc, unchanged when both or neither.
- Standard mode (FWFT=0): on rd_acc, data_out ← mem[rd_ptr] at the clock edge. Otherwise data_out holds its last value.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] combinationally whenever empty=0. rd_acc consumes the displayed word. data_out is don't-care while empty, but the bench must see no X once a word is present.
- Flags: almost_full and almost_empty are combinational from the count register, with no additional latency.
- Error flags: overflow and underflow are sticky and are cleared only by rst or flush.
- flush: on the next edge, pointers, count, overflow and underflow go to 0. flush has priority over wr_en and rd_en in the same cycle; those requests are dropped and set no error flags. Memory contents are not cleared. data_out (standard mode) holds its value.

## Timing
- Reset values (asynchronous, immediate on rst assertion): count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0, wr_ptr=rd_ptr=0.
- After rst deasserts, the first accepted write can occur on the first rising edge.
- rst asserted mid-operation discards all contents immediately. Flags take their reset values without waiting for a clock edge.
- Write → empty deassert: 1 edge. The write at edge N gives empty=0 after N.
- Standard read latency: rd_acc at edge N makes data_out valid after N.
- FWFT read: the word is visible on data_out in the cycle after the edge that wrote it into an empty FIFO. The next word is visible in the cycle after the edge that accepted the pop.
- Back-to-back throughput is one write and one read per cycle, including at full (read frees a slot; the write is accepted on the next cycle) and at empty.
- There are no combinational paths from wr_en or rd_en to any output, except data_out in FWFT mode, which depends on rd_ptr (a register).

## Test plan
- Reset and fill (DEPTH=5, W=8, FWFT=0):
  - Stimulus: reset, then write 0x10..0x14 on consecutive cycles.
  - Required response: count steps 1..5. almost_full rises when count=4 (AF_THRESH=4). full=1 after the 5th write. A 6th write sets overflow=1 and leaves count=5.
- Drain order and latency (standard mode):
  - Stimulus: from full, assert rd_en for 6 cycles.
  - Required response: data_out = 0x10..0x14, each one edge after its rd_acc. empty=1 after the 5th pop. The 6th pop sets underflow=1 and data_out holds 0x14.
- Wrap-around:
  - Stimulus: DEPTH=5; run 13 interleaved write/read pairs with counting data 0x00..0x0C.
  - Required response: read sequence equals write sequence; count never exceeds 1; pointers wrap 4→0 with no corruption.
- Simultaneous at boundaries:
  - Stimulus: at full, assert wr_en=rd_en=1 for one cycle; at empty, assert wr_en=rd_en=1 for one cycle.
  - Required response: at full, count becomes 4 and overflow=1. At empty, count becomes 1, underflow=1, and the written word is the next word read.
- FWFT mode (FWFT=1):
  - Stimulus: write 0xA5 into an empty FIFO, then write 0x3C, then pop twice.
  - Required response: data_out=0xA5 the cycle after the first write with no rd_en. After the first pop, data_out=0x3C. After the second pop, empty=1.
- Flush and asynchronous reset:
  - Stimulus: with count=3 and overflow=1, assert flush together with wr_en.
  - Required response: after the edge, count=0, empty=1, overflow=0, and the write is dropped.
  - Stimulus: assert rst mid-cycle while count=2.
  - Required response: all outputs take their reset values before the next edge.
